// File: rtl/ula_pkg.sv
// Shared widths, op encoding and FSM states for the ula_seq sequencer.
package ula_pkg;
  localparam int DW   = 4;  // data width
  localparam int NREG = 4;  // register file entries
  localparam int AW   = 2;  // register index width

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SHR = 2'b10,
    OP_SHL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_e;
endpackage

// File: rtl/ula_regfile.sv
// 4x4 register file: one synchronous write port, three combinational reads.
module ula_regfile
  import ula_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_ra_addr,
  input  logic [AW-1:0] i_rb_addr,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [DW-1:0] o_ra_data,
  output logic [DW-1:0] o_rb_data,
  output logic [DW-1:0] o_dbg_data
);
  logic [NREG-1:0][DW-1:0] r_mem;

  // Write port; reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) r_mem <= '0;
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_ra_data  = r_mem[i_ra_addr];
  assign o_rb_data  = r_mem[i_rb_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];
endmodule

// File: rtl/ula_seq.sv
// Sequencer: loads registers, issues one command to an external ALU,
// writes the result back. IDLE -> EXEC -> WB per command.
module ula_seq
  import ula_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic          cmd_imm_en,
  input  logic [DW-1:0] cmd_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_sel,
  input  logic [DW-1:0] alu_resul,
  input  logic          alu_flag,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          flag,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  state_e        r_state;
  logic [DW-1:0] r_a, r_b, r_res;
  op_e           r_sel;
  logic [AW-1:0] r_rd;
  logic          r_flag, r_done;

  logic          w_idle, w_ld_acc, w_cmd_acc, w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata, w_ra_data, w_rb_data;

  // Loads take priority over commands; nothing is accepted during reset.
  assign w_idle    = (r_state == ST_IDLE) && !rst;
  assign ld_ready  = w_idle;
  assign cmd_ready = w_idle && !ld_valid;
  assign w_ld_acc  = ld_valid && ld_ready;
  assign w_cmd_acc = cmd_valid && cmd_ready;

  // Single write port shared by loads (IDLE) and write-back (EXEC).
  assign w_we    = w_ld_acc || (r_state == ST_EXEC);
  assign w_waddr = (r_state == ST_EXEC) ? r_rd : ld_addr;
  assign w_wdata = (r_state == ST_EXEC) ? alu_resul : ld_data;

  ula_regfile u_rf (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_ra_addr  (cmd_ra),
    .i_rb_addr  (cmd_rb),
    .i_dbg_addr (rd_addr),
    .o_ra_data  (w_ra_data),
    .o_rb_data  (w_rb_data),
    .o_dbg_data (rd_data)
  );

  // FSM plus operand/result registers; operands are captured at accept so a
  // destination that aliases a source still sees the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= OP_ADD;
      r_rd    <= '0;
      r_res   <= '0;
      r_flag  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_cmd_acc) begin
          r_a     <= w_ra_data;
          r_b     <= cmd_imm_en ? cmd_imm : w_rb_data;
          r_sel   <= op_e'(cmd_op);
          r_rd    <= cmd_rd;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_res   <= alu_resul;
          r_flag  <= alu_flag;
          r_done  <= 1'b1;
          r_state <= ST_WB;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign alu_sel = r_sel;
  assign done    = r_done;
  assign result  = r_res;
  assign flag    = r_flag;
endmodule
